// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: two single-word request ports
// plus the shared read-data/busy returns.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic              p0_err;
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic              p1_err;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_ack, p0_err, p1_ack, p1_err, rdata, busy
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p0_ack, p0_err, p1_ack, p1_err, rdata, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter/sequencer for the 32-bit data RAM: grants one single-word
// request at a time and produces the OE/WS/address/data timing the RAM needs.
module ram_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_DEPTH  = 226,
  parameter int FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_port_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  output logic               ram_oe,
  output logic               ram_ws,
  input  logic [DATA_W-1:0]  ram_dout
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_STROBE, RESP} state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = MEM_DEPTH[ADDR_W:0];

  state_t            r_state, w_state_nx;
  logic              r_id, w_id_nx;
  logic              r_err, w_err_nx;
  logic              r_last, w_last_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [DATA_W-1:0] r_wdata, w_wdata_nx;
  logic [DATA_W-1:0] r_rdata, w_rdata_nx;
  logic              r_oe, w_oe_nx;
  logic              r_ws, w_ws_nx;
  logic              r_ack0, w_ack0_nx, r_ack1, w_ack1_nx;
  logic              r_err0, w_err0_nx, r_err1, w_err1_nx;
  logic              r_busy, w_busy_nx;

  logic              w_win;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Tie-break: fixed priority to port 0, or the port that did not win last.
  always_comb begin
    w_win = bus.p1_req;
    if (bus.p0_req && bus.p1_req) begin
      w_win = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
    end
    w_sel_we    = w_win ? bus.p1_we    : bus.p0_we;
    w_sel_addr  = w_win ? bus.p1_addr  : bus.p0_addr;
    w_sel_wdata = w_win ? bus.p1_wdata : bus.p0_wdata;
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    w_state_nx = r_state;
    w_id_nx    = r_id;
    w_err_nx   = r_err;
    w_last_nx  = r_last;
    w_addr_nx  = r_addr;
    w_wdata_nx = r_wdata;
    w_rdata_nx = '0;
    w_oe_nx    = 1'b0;
    w_ws_nx    = 1'b0;
    w_ack0_nx  = 1'b0;
    w_ack1_nx  = 1'b0;
    w_err0_nx  = 1'b0;
    w_err1_nx  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          w_id_nx   = w_win;
          w_last_nx = w_win;
          if ({1'b0, w_sel_addr} >= LP_DEPTH) begin
            w_err_nx   = 1'b1;
            w_state_nx = RESP;
          end else begin
            w_err_nx  = 1'b0;
            w_addr_nx = w_sel_addr;
            if (w_sel_we) begin
              w_wdata_nx = w_sel_wdata;
              w_state_nx = WR_SETUP;
            end else begin
              w_oe_nx    = 1'b1;
              w_state_nx = RD;
            end
          end
        end
      end
      RD: begin
        w_rdata_nx = ram_dout;
        w_state_nx = RESP;
      end
      WR_SETUP: begin
        w_ws_nx    = 1'b1;
        w_state_nx = WR_STROBE;
      end
      WR_STROBE: w_state_nx = RESP;
      RESP:      w_state_nx = IDLE;
      default:   w_state_nx = IDLE;
    endcase
    if (w_state_nx == RESP && r_state != RESP) begin
      w_ack0_nx = ~w_id_nx;
      w_ack1_nx = w_id_nx;
      w_err0_nx = ~w_id_nx & w_err_nx;
      w_err1_nx = w_id_nx & w_err_nx;
    end
    w_busy_nx = (w_state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_id    <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_oe    <= 1'b0;
      r_ws    <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_id    <= w_id_nx;
      r_err   <= w_err_nx;
      r_last  <= w_last_nx;
      r_addr  <= w_addr_nx;
      r_wdata <= w_wdata_nx;
      r_rdata <= w_rdata_nx;
      r_oe    <= w_oe_nx;
      r_ws    <= w_ws_nx;
      r_ack0  <= w_ack0_nx;
      r_ack1  <= w_ack1_nx;
      r_err0  <= w_err0_nx;
      r_err1  <= w_err1_nx;
      r_busy  <= w_busy_nx;
    end
  end

  assign ram_addr   = r_addr;
  assign ram_wdata  = r_wdata;
  assign ram_oe     = r_oe;
  assign ram_ws     = r_ws;
  assign bus.rdata  = r_rdata;
  assign bus.busy   = r_busy;
  assign bus.p0_ack = r_ack0;
  assign bus.p1_ack = r_ack1;
  assign bus.p0_err = r_err0;
  assign bus.p1_err = r_err1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model (latency per request type, memory array).
module tb_ram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int DEPTH = 226;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  logic [AW-1:0] ram_addr0, ram_addr1;
  logic [DW-1:0] ram_wdata0, ram_wdata1, ram_dout0, ram_dout1;
  logic          ram_oe0, ram_oe1, ram_ws0, ram_ws1;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_oe(ram_oe0),
    .ram_ws(ram_ws0), .ram_dout(ram_dout0));

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_oe(ram_oe1),
    .ram_ws(ram_ws1), .ram_dout(ram_dout1));

  assign bus1.p0_req   = bus0.p0_req;
  assign bus1.p0_we    = bus0.p0_we;
  assign bus1.p0_addr  = bus0.p0_addr;
  assign bus1.p0_wdata = bus0.p0_wdata;
  assign bus1.p1_req   = bus0.p1_req;
  assign bus1.p1_we    = bus0.p1_we;
  assign bus1.p1_addr  = bus0.p1_addr;
  assign bus1.p1_wdata = bus0.p1_wdata;

  function automatic logic [31:0] init_word(input int unsigned a);
    return (a == 5) ? 32'hDEADBEEF : (32'h5A000000 | (a * 32'h00010101));
  endfunction

  // RAM models: async read, write on WS rising edge
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  bit            wr0  [256];
  bit            wr1  [256];
  assign ram_dout0 = wr0[ram_addr0] ? mem0[ram_addr0] : init_word(ram_addr0);
  assign ram_dout1 = wr1[ram_addr1] ? mem1[ram_addr1] : init_word(ram_addr1);
  always @(posedge ram_ws0) begin
    mem0[ram_addr0] <= ram_wdata0;
    wr0[ram_addr0]  <= 1'b1;
  end
  always @(posedge ram_ws1) begin
    mem1[ram_addr1] <= ram_wdata1;
    wr1[ram_addr1]  <= 1'b1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: one outstanding request, age counted in cycles
  logic [31:0] m_mem [256];
  bit          m_wr  [256];
  bit          m_active = 0;
  bit          m_last = 1;
  bit          m_port = 0;
  bit          m_we = 0;
  bit          m_err = 0;
  int          m_age = 0;
  int          m_lat = 0;
  logic [7:0]  m_a = '0;
  logic [31:0] m_d = '0;
  logic [7:0]  m_addr = '0;
  logic [31:0] m_wdata = '0;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    return m_wr[a] ? m_mem[a] : init_word(a);
  endfunction

  task automatic model_reset();
    m_active = 0; m_last = 1; m_age = 0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_update();
    bit w;
    if (!rst_n) begin
      model_reset();
    end else if (!m_active) begin
      if (bus0.p0_req || bus0.p1_req) begin
        if (bus0.p0_req && bus0.p1_req) w = !m_last;
        else w = bus0.p1_req;
        m_port = w; m_last = w;
        m_we  = w ? bus0.p1_we    : bus0.p0_we;
        m_a   = w ? bus0.p1_addr  : bus0.p0_addr;
        m_d   = w ? bus0.p1_wdata : bus0.p0_wdata;
        m_err = (int'(m_a) >= DEPTH);
        m_lat = m_err ? 1 : (m_we ? 3 : 2);
        m_active = 1; m_age = 1;
        if (!m_err) begin
          m_addr = m_a;
          if (m_we) m_wdata = m_d;
        end
      end
    end else begin
      m_age++;
      if (m_we && !m_err && m_age == 2) begin
        m_mem[m_a] = m_d; m_wr[m_a] = 1;
      end
      if (m_age > m_lat) m_active = 0;
    end
  endtask

  task automatic check_all();
    bit ack;
    ack = m_active && (m_age == m_lat);
    chk("busy",      bus0.busy,   m_active);
    chk("p0_ack",    bus0.p0_ack, ack && !m_port);
    chk("p0_err",    bus0.p0_err, ack && !m_port && m_err);
    chk("p1_ack",    bus0.p1_ack, ack && m_port);
    chk("p1_err",    bus0.p1_err, ack && m_port && m_err);
    chk("rdata",     bus0.rdata,  (ack && !m_we && !m_err) ? m_read(m_a) : 32'h0);
    chk("ram_oe",    ram_oe0,     m_active && !m_err && !m_we && m_age == 1);
    chk("ram_ws",    ram_ws0,     m_active && !m_err && m_we && m_age == 2);
    chk("ram_addr",  ram_addr0,   m_addr);
    chk("ram_wdata", ram_wdata0,  m_wdata);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [7:0] a, input logic [31:0] d);
    if (port) begin
      bus0.p1_req = req; bus0.p1_we = we; bus0.p1_addr = a; bus0.p1_wdata = d;
    end else begin
      bus0.p0_req = req; bus0.p0_we = we; bus0.p0_addr = a; bus0.p0_wdata = d;
    end
  endtask

  int g0[$];
  int g1[$];
  int exp0[4] = '{0, 1, 0, 1};

  initial begin
    drive(0, 0, 0, 8'h0, 32'h0);
    drive(1, 0, 0, 8'h0, 32'h0);
    step(); step();
    chk("rst_busy", bus0.busy, 1'b0);
    chk("rst_ws_oe", {ram_ws0, ram_oe0}, 2'b00);
    rst_n = 1'b1;
    step();

    // p0 read of preloaded word
    drive(0, 1, 0, 8'h05, 32'h0);
    step();
    chk("t1_oe", ram_oe0, 1'b1);
    drive(0, 0, 0, 8'h05, 32'h0);
    step();
    chk("t1_ack", {bus0.p0_ack, bus0.p1_ack}, 2'b10);
    chk("t1_rdata", bus0.rdata, 32'hDEADBEEF);
    step();

    // p1 write then read back
    drive(1, 1, 1, 8'h10, 32'h12345678);
    step();
    drive(1, 0, 0, 8'h10, 32'h0);
    chk("t2_ws_setup", ram_ws0, 1'b0);
    step();
    chk("t2_ws", ram_ws0, 1'b1);
    step();
    chk("t2_ack", bus0.p1_ack, 1'b1);
    step();
    drive(1, 1, 0, 8'h10, 32'h0);
    step();
    drive(1, 0, 0, 8'h10, 32'h0);
    step();
    chk("t2_rdata", bus0.rdata, 32'h12345678);
    step();

    // out-of-range read
    drive(0, 1, 0, 8'hE2, 32'h0);
    step();
    chk("t4_ack_err", {bus0.p0_ack, bus0.p0_err}, 2'b11);
    chk("t4_rdata", bus0.rdata, 32'h0);
    chk("t4_oe_ws", {ram_oe0, ram_ws0}, 2'b00);
    drive(0, 0, 0, 8'h00, 32'h0);
    step(); step();

    // request dropped after acceptance of a write
    drive(0, 1, 1, 8'h20, 32'hCAFEF00D);
    step();
    drive(0, 0, 0, 8'h20, 32'h0);
    step(); step();
    chk("t6_ack", bus0.p0_ack, 1'b1);
    step();
    drive(0, 1, 0, 8'h20, 32'h0);
    step();
    drive(0, 0, 0, 8'h20, 32'h0);
    step();
    chk("t6_rdata", bus0.rdata, 32'hCAFEF00D);
    step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 255)), $urandom);
      drive(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 255)), $urandom);
      step();
    end
    drive(0, 0, 0, 8'h0, 32'h0);
    drive(1, 0, 0, 8'h0, 32'h0);
    for (int i = 0; i < 5; i++) step();

    // reset during WR_STROBE
    drive(1, 1, 1, 8'h33, 32'hA1B2C3D4);
    step();
    drive(1, 0, 0, 8'h33, 32'h0);
    step();
    chk("t5_ws_pre", ram_ws0, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_ws_rst", ram_ws0, 1'b0);
    chk("t5_busy_rst", bus0.busy, 1'b0);
    chk("t5_no_ack", {bus0.p0_ack, bus0.p1_ack}, 2'b00);
    step();
    rst_n = 1'b1;
    step();

    // both ports request continuously
    drive(0, 1, 0, 8'h01, 32'h0);
    drive(1, 1, 0, 8'h02, 32'h0);
    for (int i = 0; i < 40 && (g0.size() < 4 || g1.size() < 4); i++) begin
      step();
      if (bus0.p0_ack) g0.push_back(0);
      if (bus0.p1_ack) g0.push_back(1);
      if (bus1.p0_ack) g1.push_back(0);
      if (bus1.p1_ack) g1.push_back(1);
    end
    chk("t3_rr_count", (g0.size() >= 4), 1'b1);
    chk("t3_fp_count", (g1.size() >= 4), 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_rr_grant%0d", k), (k < g0.size()) ? g0[k] : 7, exp0[k]);
      chk($sformatf("t3_fp_grant%0d", k), (k < g1.size()) ? g1[k] : 7, 0);
    end
    drive(0, 0, 0, 8'h0, 32'h0);
    drive(1, 0, 0, 8'h0, 32'h0);
    for (int i = 0; i < 4; i++) step();

    // write interrupted after WS rise must have landed
    drive(0, 1, 0, 8'h33, 32'h0);
    step();
    drive(0, 0, 0, 8'h33, 32'h0);
    step();
    chk("t5_committed", bus0.rdata, 32'hA1B2C3D4);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
